kernel_cc_start_token_sched: RTL and testbench
==============================================

# kernel_cc_start_token_sched

Start-token scheduler for a dataflow region. It takes the region's ap_start/ap_ready handshake and fans one start token per iteration into NUM_PROC per-process start FIFOs (write side: if_write/if_full_n, data fixed 1). It collects per-process completion pulses, bounds the number of in-flight iterations, and presents region-level ap_done/ap_continue/ap_idle to the parent controller.

## Interface
- NUM_PROC, 4: number of downstream processes / start FIFOs (1..16).
- MAX_INFLIGHT, 4: maximum iterations issued but not yet retired (1..7).
- CNT_WIDTH, 3: width of in-flight and per-process done counters; must satisfy 2^CNT_WIDTH > MAX_INFLIGHT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  parent requests one iteration; held until ap_ready.
- ap_ready  out  1  combinational; iteration accepted this cycle.
- ap_done  out  1  registered; one iteration retired, held until ap_continue.
- ap_continue  in  1  parent acknowledges ap_done.
- ap_idle  out  1  no iteration issued, partially issued or in flight.
- start_write  out  NUM_PROC  per-FIFO write strobe (if_write; if_write_ce tied 1 outside).
- start_full_n  in  NUM_PROC  per-FIFO if_full_n.
- proc_done  in  NUM_PROC  one-cycle pulse per process iteration completion.
- inflight_cnt  out  CNT_WIDTH  current in-flight count.
- err  out  1  sticky protocol error.

## Operation
- State: issued mask[NUM_PROC], inflight[CNT_WIDTH], done_cnt[i][CNT_WIDTH], done_pending, err.
- can_issue = (inflight < MAX_INFLIGHT).
- start_write[i] = ap_start & can_issue & ~mask[i] & start_full_n[i].
- all_issued = &(mask | start_write).
- ap_ready = ap_start & can_issue & all_issued.
- Mask update:
  - On ap_ready, mask clears.
  - Otherwise mask |= start_write. Partial issue persists across cycles until every FIFO has accepted.
- Inflight update:
  - Increments on ap_ready.
  - Decrements on retire = ap_done & ap_continue.
  - Both in one cycle: unchanged.
- done_cnt[i] increments on proc_done[i].
- Completion event: comp = (all done_cnt[i] != 0) & (~done_pending | retire).
  - On comp, every done_cnt[i] decrements (net 0 for any i with a simultaneous proc_done[i]) and done_pending <= 1.
  - On retire without comp, done_pending <= 0.
- ap_done = done_pending. ap_idle = (inflight == 0) & (mask == 0).
- err sets and holds when proc_done[i] arrives while done_cnt[i] == inflight, i.e. more completions than issued iterations. That done_cnt[i] does not increment.
- ap_continue without ap_done is ignored.
- ap_start dropping mid-partial-issue leaves mask intact. Resume continues with the remaining FIFOs. No FIFO is written twice per iteration.

## Timing
- Reset (synchronous, active-high, dominates every other input): mask=0, inflight=0, all done_cnt=0, done_pending=0, err=0.
- Outputs after reset: ap_done=0, ap_idle=1, inflight_cnt=0, err=0.
- start_write and ap_ready are forced 0 while reset is high.
- Issue latency: if every start_full_n=1 and can_issue, start_write is all ones and ap_ready=1 in the same cycle ap_start rises. Zero-cycle latency.
- Backpressure: a FIFO with full_n=0 delays ap_ready until the cycle it accepts. Other FIFOs are written at most once.
- At inflight == MAX_INFLIGHT, start_write=0 and ap_ready=0 until a retire.
  - A retire in cycle t allows issue in cycle t+1, because can_issue is computed from registered inflight.
- Completion latency: the last proc_done pulse in cycle t gives ap_done=1 in cycle t+2 (count registered at t+1, done_pending at t+2).
- Back-to-back retire: with ap_continue held high and counts available, ap_done stays high and one iteration retires per cycle.

## Test plan
- Reset then idle: assert reset 2 cycles -> ap_idle=1, ap_done=0, inflight_cnt=0, start_write=0 even with ap_start=1 during reset.
- Single iteration, NUM_PROC=4, all full_n=1:
  - ap_start one cycle -> start_write=4'b1111 and ap_ready=1 same cycle, inflight_cnt=1.
  - proc_done pulses at cycles 5,6,7,9 -> ap_done=1 at cycle 11.
  - ap_continue -> inflight_cnt=0, ap_idle=1.
- Backpressure: full_n=4'b1011 for 3 cycles with ap_start held -> start_write=4'b1011 once, then 0. Release FIFO 2 -> start_write=4'b0100 and ap_ready=1 that cycle.
- In-flight limit, MAX_INFLIGHT=4:
  - Issue 4 iterations with no completions -> 5th ap_start gets ap_ready=0.
  - Complete and retire one -> ap_ready the following cycle.
- Retire/issue collision: with inflight=2, ap_ready and retire in the same cycle -> inflight_cnt stays 2. Two queued completions with ap_continue held -> ap_done high 2 consecutive cycles, inflight_cnt 2→1→0.
- Protocol error: proc_done[0] with inflight=0 -> err=1 next cycle and remains set until reset. done_cnt[0] stays 0.

Source files
------------

// File: rtl/kernel_cc_start_token_sched.sv
// Start-token scheduler for a dataflow region: fans one start token per iteration into
// per-process start FIFOs, collects completions and bounds the iterations in flight.
module kernel_cc_start_token_sched #(
  parameter int unsigned NUM_PROC     = 4,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  input  logic                 ap_continue,
  output logic                 ap_idle,
  output logic [NUM_PROC-1:0]  start_write,
  input  logic [NUM_PROC-1:0]  start_full_n,
  input  logic [NUM_PROC-1:0]  proc_done,
  output logic [CNT_WIDTH-1:0] inflight_cnt,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] MaxInflight = CNT_WIDTH'(MAX_INFLIGHT);

  logic [NUM_PROC-1:0]  mask_q, mask_d;
  logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] done_cnt_q [NUM_PROC];
  logic [CNT_WIDTH-1:0] done_cnt_d [NUM_PROC];
  logic                 done_pending_q, done_pending_d;
  logic                 err_q, err_d;

  logic                 can_issue;
  logic                 all_issued;
  logic                 retire;
  logic                 all_counted;
  logic                 comp;
  logic [NUM_PROC-1:0]  over_done;

  // Issue side: a FIFO is written only once per iteration; mask remembers who already has it.
  always_comb begin
    can_issue   = (inflight_q < MaxInflight);
    start_write = '0;
    if (!reset && ap_start && can_issue) begin
      start_write = ~mask_q & start_full_n;
    end
    all_issued = &(mask_q | start_write);
    ap_ready   = !reset && ap_start && can_issue && all_issued;
  end

  always_comb begin
    retire      = done_pending_q & ap_continue;
    all_counted = 1'b1;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (done_cnt_q[i] == '0) begin
        all_counted = 1'b0;
      end
    end
    // A new completion may be latched while the previous one is being retired.
    comp = all_counted & (~done_pending_q | retire);
  end

  always_comb begin
    over_done = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      done_cnt_d[i] = done_cnt_q[i];
      // More completions than iterations in flight: flag and drop the pulse.
      over_done[i]  = proc_done[i] && (done_cnt_q[i] == inflight_q);
      if (proc_done[i] && !over_done[i]) begin
        done_cnt_d[i] = done_cnt_d[i] + CNT_WIDTH'(1);
      end
      if (comp) begin
        done_cnt_d[i] = done_cnt_d[i] - CNT_WIDTH'(1);
      end
    end
    err_d = err_q | (|over_done);
  end

  always_comb begin
    mask_d = ap_ready ? '0 : (mask_q | start_write);

    inflight_d = inflight_q;
    case ({ap_ready, retire})
      2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - CNT_WIDTH'(1);
      default: inflight_d = inflight_q;
    endcase

    done_pending_d = done_pending_q;
    if (comp) begin
      done_pending_d = 1'b1;
    end else if (retire) begin
      done_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q         <= '0;
      inflight_q     <= '0;
      done_pending_q <= 1'b0;
      err_q          <= 1'b0;
      for (int i = 0; i < NUM_PROC; i++) begin
        done_cnt_q[i] <= '0;
      end
    end else begin
      mask_q         <= mask_d;
      inflight_q     <= inflight_d;
      done_pending_q <= done_pending_d;
      err_q          <= err_d;
      for (int i = 0; i < NUM_PROC; i++) begin
        done_cnt_q[i] <= done_cnt_d[i];
      end
    end
  end

  assign ap_done      = done_pending_q;
  assign ap_idle      = (inflight_q == '0) && (mask_q == '0);
  assign inflight_cnt = inflight_q;
  assign err          = err_q;

endmodule

// File: tb/tb_kernel_cc_start_token_sched.sv
// Scoreboard bench: a cycle reference model queues expected outputs, a monitor compares them.
module tb_kernel_cc_start_token_sched;

  localparam int N    = 4;
  localparam int MAXI = 4;
  localparam int CW   = 3;

  logic          clk;
  logic          reset;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic          ap_continue;
  logic          ap_idle;
  logic [N-1:0]  start_write;
  logic [N-1:0]  start_full_n;
  logic [N-1:0]  proc_done;
  logic [CW-1:0] inflight_cnt;
  logic          err;

  kernel_cc_start_token_sched #(
    .NUM_PROC    (N),
    .MAX_INFLIGHT(MAXI),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .ap_idle     (ap_idle),
    .start_write (start_write),
    .start_full_n(start_full_n),
    .proc_done   (proc_done),
    .inflight_cnt(inflight_cnt),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  sw;
    logic          rdy;
    logic          done;
    logic          idle;
    logic [CW-1:0] infl;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: tokens delivered for the open iteration, completions per process,
  // iterations accepted but not retired, a latched-but-unacknowledged completion.
  bit [N-1:0] m_wr   = '0;
  int         m_cnt[N];
  int         m_infl = 0;
  bit         m_pend = 1'b0;
  bit         m_err  = 1'b0;
  bit [N-1:0] last_sw;
  bit         last_rdy;
  int         owed[N];
  bit         hold;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit ct, input bit [N-1:0] fn,
                      input bit [N-1:0] pd);
    exp_t e;
    bit   can, all, retire, comp;
    @(posedge clk);
    #1;
    reset        = r;
    ap_start     = st;
    ap_continue  = ct;
    start_full_n = fn;
    proc_done    = pd;

    can  = (m_infl < MAXI);
    all  = 1'b1;
    e.sw = '0;
    for (int i = 0; i < N; i++) begin
      e.sw[i] = !r && st && can && !m_wr[i] && fn[i];
      if (!m_wr[i] && !e.sw[i]) all = 1'b0;
    end
    e.rdy  = !r && st && can && all;
    e.done = m_pend;
    e.idle = (m_infl == 0) && (m_wr == '0);
    e.infl = CW'(m_infl);
    e.err  = m_err;
    exp_q.push_back(e);
    last_sw  = e.sw;
    last_rdy = e.rdy;

    if (r) begin
      m_wr   = '0;
      m_infl = 0;
      m_pend = 1'b0;
      m_err  = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      retire = m_pend && ct;
      comp   = !m_pend || retire;
      for (int i = 0; i < N; i++) if (m_cnt[i] == 0) comp = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (pd[i]) begin
          if (m_cnt[i] == m_infl) m_err = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
        if (comp) m_cnt[i] = m_cnt[i] - 1;
      end
      m_wr   = e.rdy ? '0 : (m_wr | e.sw);
      m_infl = (m_infl + int'(e.rdy) - int'(retire)) & ((1 << CW) - 1);
      if (comp) m_pend = 1'b1;
      else if (retire) m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("start_write", 32'(start_write), 32'(e.sw));
        cmp("ap_ready", 32'(ap_ready), 32'(e.rdy));
        cmp("ap_done", 32'(ap_done), 32'(e.done));
        cmp("ap_idle", 32'(ap_idle), 32'(e.idle));
        cmp("inflight_cnt", 32'(inflight_cnt), 32'(e.infl));
        cmp("err", 32'(err), 32'(e.err));
      end
    end
  endtask

  task automatic run_directed();
    // Reset with ap_start held high.
    step(1, 1, 0, 4'hF, 0);
    cmp("rst_start_write", 32'(start_write), 0);
    cmp("rst_ap_ready", 32'(ap_ready), 0);
    step(1, 1, 0, 4'hF, 0);
    step(0, 0, 0, 4'hF, 0);
    cmp("rst_idle", 32'(ap_idle), 1);
    cmp("rst_done", 32'(ap_done), 0);
    cmp("rst_inflight", 32'(inflight_cnt), 0);

    // Single iteration with staggered completions.
    step(0, 1, 0, 4'hF, 0);
    cmp("single_sw", 32'(start_write), 32'hF);
    cmp("single_ready", 32'(ap_ready), 1);
    step(0, 0, 0, 4'hF, 4'b0001);
    cmp("single_inflight", 32'(inflight_cnt), 1);
    step(0, 0, 0, 4'hF, 4'b0010);
    step(0, 0, 0, 4'hF, 4'b0100);
    step(0, 0, 0, 4'hF, 4'b0000);
    step(0, 0, 0, 4'hF, 4'b1000);
    step(0, 0, 0, 4'hF, 0);
    cmp("single_done_t1", 32'(ap_done), 0);
    step(0, 0, 0, 4'hF, 0);
    cmp("single_done_t2", 32'(ap_done), 1);
    step(0, 0, 1, 4'hF, 0);
    step(0, 0, 0, 4'hF, 0);
    cmp("single_retired", 32'(inflight_cnt), 0);
    cmp("single_idle", 32'(ap_idle), 1);

    // Backpressure on FIFO 2.
    step(0, 1, 0, 4'b1011, 0);
    cmp("bp_first_sw", 32'(start_write), 32'b1011);
    cmp("bp_first_ready", 32'(ap_ready), 0);
    step(0, 1, 0, 4'b1011, 0);
    cmp("bp_second_sw", 32'(start_write), 0);
    step(0, 1, 0, 4'b1011, 0);
    step(0, 1, 0, 4'hF, 0);
    cmp("bp_release_sw", 32'(start_write), 32'b0100);
    cmp("bp_release_ready", 32'(ap_ready), 1);
    step(0, 0, 0, 4'hF, 4'hF);
    step(0, 0, 0, 4'hF, 0);
    step(0, 0, 1, 4'hF, 0);

    // In-flight limit.
    repeat (4) step(0, 1, 0, 4'hF, 0);
    step(0, 1, 0, 4'hF, 0);
    cmp("limit_ready", 32'(ap_ready), 0);
    cmp("limit_sw", 32'(start_write), 0);
    step(0, 1, 0, 4'hF, 4'hF);
    step(0, 1, 0, 4'hF, 0);
    step(0, 1, 1, 4'hF, 0);
    cmp("limit_retire_ready", 32'(ap_ready), 0);
    step(0, 1, 0, 4'hF, 0);
    cmp("limit_after_retire", 32'(ap_ready), 1);
    repeat (4) step(0, 0, 0, 4'hF, 4'hF);
    repeat (8) step(0, 0, 1, 4'hF, 0);
    cmp("limit_drained", 32'(inflight_cnt), 0);

    // Retire/issue collision and back-to-back retire.
    step(0, 1, 0, 4'hF, 0);
    step(0, 1, 0, 4'hF, 0);
    step(0, 0, 0, 4'hF, 4'hF);
    step(0, 0, 0, 4'hF, 0);
    step(0, 1, 1, 4'hF, 0);
    cmp("coll_ready", 32'(ap_ready), 1);
    step(0, 0, 0, 4'hF, 4'hF);
    cmp("coll_inflight", 32'(inflight_cnt), 2);
    step(0, 0, 0, 4'hF, 4'hF);
    step(0, 0, 1, 4'hF, 0);
    cmp("b2b_done0", 32'(ap_done), 1);
    cmp("b2b_infl0", 32'(inflight_cnt), 2);
    step(0, 0, 1, 4'hF, 0);
    cmp("b2b_done1", 32'(ap_done), 1);
    cmp("b2b_infl1", 32'(inflight_cnt), 1);
    step(0, 0, 1, 4'hF, 0);
    cmp("b2b_done2", 32'(ap_done), 0);
    cmp("b2b_infl2", 32'(inflight_cnt), 0);

    // Protocol error: completion with nothing in flight.
    step(0, 0, 0, 4'hF, 4'b0001);
    step(0, 0, 0, 4'hF, 0);
    cmp("err_set", 32'(err), 1);
    step(0, 1, 0, 4'hF, 0);
    step(0, 0, 0, 4'hF, 4'b1110);
    step(0, 0, 0, 4'hF, 0);
    step(0, 0, 0, 4'hF, 0);
    cmp("err_cnt_not_counted", 32'(ap_done), 0);
    cmp("err_sticky", 32'(err), 1);
    step(0, 0, 0, 4'hF, 4'b0001);
    step(0, 0, 0, 4'hF, 0);
    step(0, 0, 0, 4'hF, 0);
    cmp("err_late_done", 32'(ap_done), 1);
    step(0, 0, 1, 4'hF, 0);
    step(1, 0, 0, 4'hF, 0);
    step(0, 0, 0, 4'hF, 0);
    cmp("err_cleared", 32'(err), 0);
  endtask

  task automatic run_random();
    bit         r, st, ct;
    bit [N-1:0] fn, pd;
    hold = 1'b0;
    for (int i = 0; i < N; i++) owed[i] = 0;
    repeat (3000) begin
      r  = ($urandom_range(0, 199) == 0);
      st = hold ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) != 0);
      ct = 1'($urandom_range(0, 1));
      pd = '0;
      for (int i = 0; i < N; i++) begin
        fn[i] = ($urandom_range(0, 3) != 0);
        if (owed[i] > 0 && $urandom_range(0, 2) == 0) begin
          pd[i]   = 1'b1;
          owed[i] = owed[i] - 1;
        end
      end
      step(r, st, ct, fn, pd);
      if (r) begin
        hold = 1'b0;
        for (int i = 0; i < N; i++) owed[i] = 0;
      end else begin
        hold = st && !last_rdy;
        if (last_rdy) for (int i = 0; i < N; i++) owed[i] = owed[i] + 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    reset        = 1'b1;
    ap_start     = 1'b0;
    ap_continue  = 1'b0;
    start_full_n = '1;
    proc_done    = '0;
    repeat (2) @(posedge clk);
    fork
      run_monitor();
      begin
        run_directed();
        run_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    join_any
  end

endmodule
